// File: rtl/sobel_window_gen.sv
// sobel_window_gen: streaming 3x3 neighbourhood builder for the Sobel kernels.
// Two line buffers hold the previous image lines. A 3x3 register window slides
// one column per accepted pixel. Once a complete neighbourhood exists (row >= 2,
// col >= 2), the window is offered downstream and input is stalled until it is taken.
//
// Handshakes:
//   upstream   : a pixel transfers on a rising edge when pix_valid && !busy_out.
//   downstream : a window transfers on a rising edge when valid_out && !busy_in.
//   busy_out and valid_out depend only on the state register.
module sobel_window_gen #(
  parameter int p_data_bits = 8,
  parameter int p_width     = 640,
  parameter int p_height    = 480
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     pix_valid,
  input  logic [p_data_bits-1:0]   pix_in,
  output logic                     busy_out,
  output logic                     valid_out,
  input  logic                     busy_in,
  output logic [9*p_data_bits-1:0] data_out,
  output logic                     frame_done,
  output logic                     dbg_state_o
);

  localparam int COL_W = $clog2(p_width);
  localparam int ROW_W = $clog2(p_height);

  typedef enum logic {ST_ACCEPT = 1'b0, ST_OFFER = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic [p_data_bits-1:0]   win_q [9];
  logic [p_data_bits-1:0]   win_d [9];
  logic                     last_q, last_d;
  logic                     frame_done_q, frame_done_d;

  // Line buffers are storage only: they have no reset, and are never emitted before being refilled.
  logic [p_data_bits-1:0]   lb0_q [p_width];
  logic [p_data_bits-1:0]   lb1_q [p_width];

  logic pix_xfer, win_xfer, win_done, at_last_col, at_last_row;

  assign pix_xfer    = pix_valid && (state_q == ST_ACCEPT);
  assign win_xfer    = (state_q == ST_OFFER) && !busy_in;
  assign at_last_col = (col_q == COL_W'(p_width - 1));
  assign at_last_row = (row_q == ROW_W'(p_height - 1));
  assign win_done    = pix_xfer && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

  assign frame_done  = frame_done_q;
  assign dbg_state_o = state_q;

  // Next state and handshake outputs, decoded from the state register only.
  always_comb begin
    state_d   = state_q;
    busy_out  = 1'b0;
    valid_out = 1'b0;
    case (state_q)
      ST_ACCEPT: begin
        if (win_done) state_d = ST_OFFER;
      end
      ST_OFFER: begin
        busy_out  = 1'b1;
        valid_out = 1'b1;
        if (!busy_in) state_d = ST_ACCEPT;
      end
      default: state_d = ST_ACCEPT;
    endcase
  end

  // Raster position of the next input pixel, plus the frame-end tracking flags.
  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    last_d       = last_q;
    frame_done_d = win_xfer && last_q;
    if (pix_xfer) begin
      if (at_last_col) begin
        col_d = '0;
        row_d = at_last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
    if (win_done) last_d = at_last_col && at_last_row;
  end

  // Window shift: each row moves one column left, and the new right column is {lb1, lb0, pixel}.
  always_comb begin
    win_d = win_q;
    if (pix_xfer) begin
      for (int r = 0; r < 3; r++) begin
        win_d[3*r]     = win_q[3*r+1];
        win_d[3*r + 1] = win_q[3*r+2];
      end
      win_d[2] = lb1_q[col_q];
      win_d[5] = lb0_q[col_q];
      win_d[8] = pix_in;
    end
  end

  // Pack the window row-major, with slot 0 (top-left) at the MSBs.
  always_comb begin
    data_out = '0;
    for (int k = 0; k < 9; k++) begin
      data_out[(9-k)*p_data_bits-1 -: p_data_bits] = win_q[k];
    end
  end

  // Control and window registers.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= ST_ACCEPT;
      col_q        <= '0;
      row_q        <= '0;
      last_q       <= 1'b0;
      frame_done_q <= 1'b0;
      for (int k = 0; k < 9; k++) win_q[k] <= '0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      last_q       <= last_d;
      frame_done_q <= frame_done_d;
      win_q        <= win_d;
    end
  end

  // Line buffer update: the older line drops into lb1 as the new pixel enters lb0.
  always_ff @(posedge i_clk) begin
    if (pix_xfer) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= pix_in;
    end
  end

endmodule
